// File: rtl/raster_scan_counter_pkg.sv
// Shared constants for the raster scan counter:
// FSM encoding, default widths and VGA frame limits.
package scan_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int XW_DEF = 10;
    localparam int YW_DEF = 10;

    localparam int X_LIM_VGA = 639;
    localparam int Y_LIM_VGA = 479;

endpackage

// File: rtl/raster_scan_counter_if.sv
// Control/pixel bundle between the control FSM, the scan
// counter and the per-pixel pipeline.
interface raster_scan_counter_if
    import scan_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
);

    logic          clk_en;
    logic          pause;
    logic          start;
    logic          abort;
    logic          continuous;
    logic [XW-1:0] x_lim;
    logic [YW-1:0] y_lim;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          busy;
    logic          line_tick;
    logic          frame_tick;
    logic          done;

    modport master (
        output clk_en, pause, start, abort, continuous,
        output x_lim, y_lim,
        input  x, y, busy, line_tick, frame_tick, done
    );

    modport slave (
        input  clk_en, pause, start, abort, continuous,
        input  x_lim, y_lim,
        output x, y, busy, line_tick, frame_tick, done
    );

endinterface

// File: rtl/raster_scan_counter_axis_counter.sv
// One axis of the raster walk: counts 0..lim and wraps,
// with a clear that overrides the increment.
module axis_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    input  logic [W-1:0] lim,
    output logic [W-1:0] q,
    output logic         at_lim
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign at_lim = (q_q == lim);
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (inc) begin
            q_d = at_lim ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/raster_scan_counter.sv
// Two-axis raster scan counter: IDLE/RUN FSM, per-frame
// limit latches, line/frame ticks and one-shot done pulse.
module raster_scan_counter
    import scan_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    raster_scan_counter_if.slave  bus
);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [XW-1:0] xl_q;
    logic [XW-1:0] xl_d;
    logic [YW-1:0] yl_q;
    logic [YW-1:0] yl_d;
    logic          done_q;
    logic          done_d;

    logic          run;
    logic          adv;
    logic          go;
    logic          kill;
    logic          frame_end;
    logic          relatch;
    logic          x_at;
    logic          y_at;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    assign run  = (state_q == ST_RUN);
    assign adv  = run & bus.clk_en & ~bus.pause;
    assign go   = ~run & bus.start & ~bus.abort;
    assign kill = run & bus.abort;

    // abort wins over a coincident frame-end advance
    assign frame_end = adv & x_at & y_at & ~bus.abort;
    assign relatch   = go | (frame_end & bus.continuous);

    always_comb begin
        state_d = state_q;
        if (go) begin
            state_d = ST_RUN;
        end else if (kill) begin
            state_d = ST_IDLE;
        end else if (frame_end & ~bus.continuous) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        xl_d   = relatch ? bus.x_lim : xl_q;
        yl_d   = relatch ? bus.y_lim : yl_q;
        done_d = frame_end & ~bus.continuous;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            xl_q    <= '0;
            yl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            done_q  <= done_d;
        end
    end

    axis_counter #(.W(XW)) u_x (
        .clk    (clk),
        .reset  (reset),
        .inc    (adv),
        .clear  (go | kill),
        .lim    (xl_q),
        .q      (x_q),
        .at_lim (x_at)
    );

    axis_counter #(.W(YW)) u_y (
        .clk    (clk),
        .reset  (reset),
        .inc    (adv & x_at),
        .clear  (go | kill),
        .lim    (yl_q),
        .q      (y_q),
        .at_lim (y_at)
    );

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.busy       = run;
    assign bus.line_tick  = run & x_at;
    assign bus.frame_tick = run & x_at & y_at;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_raster_scan_counter.sv
// Scoreboard bench for raster_scan_counter.
module tb_raster_scan_counter;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       lt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    raster_scan_counter_if #(.XW(10), .YW(10)) bus ();

    raster_scan_counter #(.XW(10), .YW(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_frame(input int xl, input int yl);
        for (int yy = 0; yy <= yl; yy++) begin
            for (int xx = 0; xx <= xl; xx++) begin
                sb.push_back('{10'(xx), 10'(yy), xx == xl,
                               (xx == xl) && (yy == yl)});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({bus.busy, bus.done, bus.line_tick, bus.frame_tick} !== 4'b0 ||
            bus.x !== 10'd0 || bus.y !== 10'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%0b done=%0b x=%0d y=%0d, want all 0",
                     bus.busy, bus.done, bus.x, bus.y);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%0b done=%0b, want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_one_shot(input int xl, input int yl, input bit stall);
        int   nb = 0;
        int   holds = 0;
        int   pl = 0;
        bit   stalled = 0;
        bit   ce = 1;
        int   npix = (xl + 1) * (yl + 1);
        exp_t e;
        sb.delete();
        push_frame(xl, yl);
        bus.clk_en = 1'b1;
        bus.pause = 1'b0;
        bus.continuous = 1'b0;
        bus.x_lim = 10'(xl);
        bus.y_lim = 10'(yl);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (bus.busy === 1'b1 && nb < 400) begin
            nb++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL oneshot_extra: busy at x=%0d y=%0d, want idle",
                         bus.x, bus.y);
            end else begin
                e = sb[0];
                if ({bus.x, bus.y, bus.line_tick, bus.frame_tick} !==
                    {e.x, e.y, e.lt, e.ft}) begin
                    failures++;
                    $display("FAIL oneshot_pix: got x=%0d y=%0d lt=%0b ft=%0b, want x=%0d y=%0d lt=%0b ft=%0b",
                             bus.x, bus.y, bus.line_tick, bus.frame_tick,
                             e.x, e.y, e.lt, e.ft);
                end
            end
            bus.start = (nb == 2);
            bus.x_lim = (nb == 2) ? 10'd7 : 10'(xl);
            if (stall && !stalled && bus.x == 10'd2 && bus.y == 10'd0) begin
                pl = 5;
                stalled = 1;
            end
            bus.pause = (pl > 0);
            if (pl > 0) pl--;
            else if (stalled) ce = ~ce;
            bus.clk_en = ce;
            if (bus.clk_en && !bus.pause) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else begin
                holds++;
            end
            step();
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.clk_en = 1'b1;
        bus.x_lim = 10'(xl);
        checks++;
        if (nb != npix + holds || sb.size() != 0) begin
            failures++;
            $display("FAIL oneshot_len: busy=%0d left=%0d, want busy=%0d left=0",
                     nb, sb.size(), npix + holds);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
            bus.x !== 10'd0 || bus.y !== 10'd0) begin
            failures++;
            $display("FAIL oneshot_done: done=%0b busy=%0b x=%0d y=%0d, want 1 0 0 0",
                     bus.done, bus.busy, bus.x, bus.y);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_pulse: done=%0b busy=%0b, want 0 0",
                     bus.done, bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        bus.x_lim = 10'd3;
        bus.y_lim = 10'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (!(bus.x == 10'd3 && bus.y == 10'd1) && n < 50) begin
            n++;
            step();
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL midrun_reach: x=%0d y=%0d, want 3 1", bus.x, bus.y);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.line_tick, bus.frame_tick} !== 4'b0 ||
            bus.x !== 10'd0 || bus.y !== 10'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%0b done=%0b x=%0d y=%0d, want all 0",
                     bus.busy, bus.done, bus.x, bus.y);
        end
    endtask

    task automatic test_continuous();
        int   nb = 0;
        exp_t e;
        sb.delete();
        push_frame(1, 1);
        push_frame(2, 1);
        bus.continuous = 1'b1;
        bus.x_lim = 10'd1;
        bus.y_lim = 10'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (bus.busy === 1'b1 && nb < 40) begin
            nb++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL cont_extra: busy at x=%0d y=%0d, want idle",
                         bus.x, bus.y);
            end else begin
                e = sb.pop_front();
                if ({bus.x, bus.y, bus.line_tick, bus.frame_tick} !==
                    {e.x, e.y, e.lt, e.ft}) begin
                    failures++;
                    $display("FAIL cont_pix: got x=%0d y=%0d lt=%0b ft=%0b, want x=%0d y=%0d lt=%0b ft=%0b",
                             bus.x, bus.y, bus.line_tick, bus.frame_tick,
                             e.x, e.y, e.lt, e.ft);
                end
            end
            if (nb == 1) bus.x_lim = 10'd2;
            if (nb == 6) bus.continuous = 1'b0;
            step();
        end
        checks++;
        if (nb != 10 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL cont_len: busy=%0d done=%0b, want 10 1", nb, bus.done);
        end
        step();
        bus.continuous = 1'b0;
    endtask

    task automatic test_abort();
        int n = 0;
        bus.x_lim = 10'd3;
        bus.y_lim = 10'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (!(bus.x == 10'd1 && bus.y == 10'd1) && n < 50) begin
            n++;
            step();
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL abort_reach: x=%0d y=%0d, want 1 1", bus.x, bus.y);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.x !== 10'd0 || bus.y !== 10'd0) begin
            failures++;
            $display("FAIL abort_run: busy=%0b done=%0b x=%0d y=%0d, want 0 0 0 0",
                     bus.busy, bus.done, bus.x, bus.y);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_nodone: busy=%0b done=%0b, want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_start_abort_idle();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL start_abort: busy=%0b, want 0", bus.busy);
        end
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_hold: busy=%0b done=%0b, want 0 0",
                     bus.busy, bus.done);
        end
    endtask

    task automatic test_max_wrap();
        bus.x_lim = 10'h3ff;
        bus.y_lim = 10'h3ff;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (1023) step();
        checks++;
        if (bus.x !== 10'h3ff || bus.y !== 10'd0 ||
            bus.line_tick !== 1'b1 || bus.frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL max_edge: x=%0d y=%0d lt=%0b ft=%0b, want 1023 0 1 0",
                     bus.x, bus.y, bus.line_tick, bus.frame_tick);
        end
        step();
        checks++;
        if (bus.x !== 10'd0 || bus.y !== 10'd1 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL max_wrap: x=%0d y=%0d busy=%0b, want 0 1 1",
                     bus.x, bus.y, bus.busy);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL max_abort: busy=%0b, want 0", bus.busy);
        end
    endtask

    initial begin
        bus.clk_en = 1'b1;
        bus.pause = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.continuous = 1'b0;
        bus.x_lim = 10'd0;
        bus.y_lim = 10'd0;
        test_reset();
        test_one_shot(3, 2, 1'b0);
        test_reset_midrun();
        test_continuous();
        test_one_shot(3, 2, 1'b1);
        test_abort();
        test_start_abort_idle();
        test_one_shot(0, 0, 1'b0);
        test_one_shot(0, 2, 1'b0);
        test_max_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
